// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: sequences the prescaler and counts its 0.1 s ticks
// into an MM:SS.t BCD time, with lap-freeze of the displayed value.
module stopwatch_ctrl #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       tick,
  output logic       pg_ena,
  output logic       pg_clear,
  output logic       running,
  output logic       lapped,
  output logic       wrap,
  output logic [2:0] disp_min_t,
  output logic [3:0] disp_min_u,
  output logic [2:0] disp_sec_t,
  output logic [3:0] disp_sec_u,
  output logic [3:0] disp_tenth
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] LAP    = 2'd3;

  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
    logic [3:0] te;
  } bcd_t;

  localparam bcd_t MAX_TIME = {3'd5, 4'd9, 3'd5, 4'd9, 4'd9};

  logic [1:0] state, state_n;
  bcd_t       live, live_n;
  bcd_t       frozen, frozen_n;
  bcd_t       disp_n;
  logic       wrap_n;
  logic       accept;

  function automatic bcd_t bcd_inc(bcd_t t);
    bcd_t r;
    r = t;
    if (t.te != 4'd9) r.te = t.te + 4'd1;
    else begin
      r.te = 4'd0;
      if (t.su != 4'd9) r.su = t.su + 4'd1;
      else begin
        r.su = 4'd0;
        if (t.st != 3'd5) r.st = t.st + 3'd1;
        else begin
          r.st = 3'd0;
          if (t.mu != 4'd9) r.mu = t.mu + 4'd1;
          else begin
            r.mu = 4'd0;
            r.mt = t.mt + 3'd1;
          end
        end
      end
    end
    return r;
  endfunction

  // Ticks are qualified by the registered state, so a tick that coincides
  // with the pulse leaving RUN/LAP still counts and one entering RUN does not.
  always_comb begin
    state_n  = state;
    live_n   = live;
    frozen_n = frozen;
    wrap_n   = 1'b0;
    accept   = tick && (state == RUN || state == LAP);

    case (state)
      IDLE: begin
        if (clear) live_n = '0;
        else if (start_stop) state_n = RUN;
      end
      RUN: begin
        if (start_stop) state_n = PAUSED;
        else if (lap) begin
          state_n  = LAP;
          frozen_n = live;
        end
      end
      LAP: begin
        if (start_stop) state_n = PAUSED;
        else if (lap) state_n = RUN;
      end
      PAUSED: begin
        if (clear) begin
          state_n = IDLE;
          live_n  = '0;
        end else if (start_stop) state_n = RUN;
      end
      default: state_n = IDLE;
    endcase

    if (accept) begin
      if (live == MAX_TIME) begin
        wrap_n = 1'b1;
        if (WRAP_EN) live_n = '0;
        else state_n = PAUSED;
      end else begin
        live_n = bcd_inc(live);
      end
    end

    disp_n = (state_n == LAP) ? frozen_n : live_n;
  end

  // Outputs are registered from the next-state values so they line up with state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      live       <= '0;
      frozen     <= '0;
      pg_ena     <= 1'b0;
      pg_clear   <= 1'b1;
      running    <= 1'b0;
      lapped     <= 1'b0;
      wrap       <= 1'b0;
      disp_min_t <= '0;
      disp_min_u <= '0;
      disp_sec_t <= '0;
      disp_sec_u <= '0;
      disp_tenth <= '0;
    end else begin
      state      <= state_n;
      live       <= live_n;
      frozen     <= frozen_n;
      pg_ena     <= (state_n == RUN) || (state_n == LAP);
      pg_clear   <= (state_n == IDLE);
      running    <= (state_n == RUN) || (state_n == LAP);
      lapped     <= (state_n == LAP);
      wrap       <= wrap_n;
      disp_min_t <= disp_n.mt;
      disp_min_u <= disp_n.mu;
      disp_sec_t <= disp_n.st;
      disp_sec_u <= disp_n.su;
      disp_tenth <= disp_n.te;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: drives both WRAP_EN variants with the same
// pulses and compares each cycle against a tenths-of-a-second integer model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic startStop = 1'b0;
  logic lapIn = 1'b0;
  logic clearIn = 1'b0;
  logic tickIn = 1'b0;

  logic       pgEnaW, pgClearW, runningW, lappedW, wrapW;
  logic [2:0] minTW, secTW;
  logic [3:0] minUW, secUW, tenthW;
  logic       pgEnaS, pgClearS, runningS, lappedS, wrapS;
  logic [2:0] minTS, secTS;
  logic [3:0] minUS, secUS, tenthS;

  stopwatch_ctrl #(.WRAP_EN(1'b1)) dutWrap (
    .clk(clk), .rst(rst), .start_stop(startStop), .lap(lapIn), .clear(clearIn), .tick(tickIn),
    .pg_ena(pgEnaW), .pg_clear(pgClearW), .running(runningW), .lapped(lappedW), .wrap(wrapW),
    .disp_min_t(minTW), .disp_min_u(minUW), .disp_sec_t(secTW), .disp_sec_u(secUW),
    .disp_tenth(tenthW)
  );

  stopwatch_ctrl #(.WRAP_EN(1'b0)) dutSat (
    .clk(clk), .rst(rst), .start_stop(startStop), .lap(lapIn), .clear(clearIn), .tick(tickIn),
    .pg_ena(pgEnaS), .pg_clear(pgClearS), .running(runningS), .lapped(lappedS), .wrap(wrapS),
    .disp_min_t(minTS), .disp_min_u(minUS), .disp_sec_t(secTS), .disp_sec_u(secUS),
    .disp_tenth(tenthS)
  );

  always #5 clk = ~clk;

  localparam int MODE_IDLE  = 10;
  localparam int MODE_RUN   = 11;
  localparam int MODE_PAUSE = 12;
  localparam int MODE_LAP   = 13;
  localparam int LAST_TENTH = 59 * 600 + 59 * 10 + 9;

  typedef struct packed {
    int tenths;
    int frozen;
    int mode;
    bit wrapPulse;
  } model_t;

  model_t mdlW, mdlS;
  logic [22:0] expQW[$];
  logic [22:0] expQS[$];
  int checks = 0;
  int errors = 0;
  int cycleNo = 0;

  function automatic model_t modelStep(model_t m, bit r, bit ss, bit lp, bit clr, bit tk,
                                       bit wrapEn);
    model_t n;
    bit counting;
    n = m;
    n.wrapPulse = 1'b0;
    if (r) begin
      n.mode = MODE_IDLE;
      n.tenths = 0;
      n.frozen = 0;
      return n;
    end
    counting = tk && (m.mode == MODE_RUN || m.mode == MODE_LAP);
    if (m.mode == MODE_IDLE) begin
      if (clr) n.tenths = 0;
      else if (ss) n.mode = MODE_RUN;
    end else if (m.mode == MODE_RUN) begin
      if (ss) n.mode = MODE_PAUSE;
      else if (lp) begin
        n.mode = MODE_LAP;
        n.frozen = m.tenths;
      end
    end else if (m.mode == MODE_LAP) begin
      if (ss) n.mode = MODE_PAUSE;
      else if (lp) n.mode = MODE_RUN;
    end else begin
      if (clr) begin
        n.mode = MODE_IDLE;
        n.tenths = 0;
      end else if (ss) n.mode = MODE_RUN;
    end
    if (counting) begin
      if (m.tenths == LAST_TENTH) begin
        n.wrapPulse = 1'b1;
        if (wrapEn) n.tenths = 0;
        else n.mode = MODE_PAUSE;
      end else begin
        n.tenths = m.tenths + 1;
      end
    end
    return n;
  endfunction

  function automatic logic [22:0] expectedOut(model_t m);
    int shown, mins, secs;
    bit active;
    shown  = (m.mode == MODE_LAP) ? m.frozen : m.tenths;
    mins   = shown / 600;
    secs   = (shown / 10) % 60;
    active = (m.mode == MODE_RUN) || (m.mode == MODE_LAP);
    return {active, m.mode == MODE_IDLE, active, m.mode == MODE_LAP, m.wrapPulse,
            3'(mins / 10), 4'(mins % 10), 3'(secs / 10), 4'(secs % 10), 4'(shown % 10)};
  endfunction

  task automatic applyStimulus(input bit r, input bit ss, input bit lp, input bit clr,
                               input bit tk);
    @(negedge clk);
    rst = r;
    startStop = ss;
    lapIn = lp;
    clearIn = clr;
    tickIn = tk;
    mdlW = modelStep(mdlW, r, ss, lp, clr, tk, 1'b1);
    mdlS = modelStep(mdlS, r, ss, lp, clr, tk, 1'b0);
    expQW.push_back(expectedOut(mdlW));
    expQS.push_back(expectedOut(mdlS));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic runTicks(input int n, input int maxGap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (maxGap > 0) idle($urandom_range(maxGap));
    end
  endtask

  task automatic checkOutput(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got ena/clr/run/lap/wrap=%b disp=%h, expected %b disp=%h",
               name, cycleNo, act[22:18], act[17:0], exp[22:18], exp[17:0]);
    end
  endtask

  // Monitor: every clock the DUTs present a fresh registered output word.
  always @(posedge clk) begin
    cycleNo++;
    #1;
    if (expQW.size() > 0)
      checkOutput("wrapEnOn", {pgEnaW, pgClearW, runningW, lappedW, wrapW,
                               minTW, minUW, secTW, secUW, tenthW}, expQW.pop_front());
    if (expQS.size() > 0)
      checkOutput("wrapEnOff", {pgEnaS, pgClearS, runningS, lappedS, wrapS,
                                minTS, minUS, secTS, secUS, tenthS}, expQS.pop_front());
  end

  initial begin
    mdlW = '{tenths: 0, frozen: 0, mode: MODE_IDLE, wrapPulse: 1'b0};
    mdlS = mdlW;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    $display("[TB] start, 25 ticks, lap freeze and release");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(25, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    runTicks(13, 2);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    $display("[TB] pause ignores ticks, clear only from pause");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(5, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(3, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);

    $display("[TB] simultaneous pulses");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(2, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(4, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);

    $display("[TB] randomized pulses");
    for (int i = 0; i < 3000; i++)
      applyStimulus($urandom_range(999) < 3, $urandom_range(99) < 5, $urandom_range(99) < 5,
                    $urandom_range(99) < 4, $urandom_range(99) < 40);

    $display("[TB] reset while lapped at 12:34.5");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(12 * 600 + 34 * 10 + 5, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    runTicks(3, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);

    $display("[TB] count to 59:59.9 and past the limit");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(LAST_TENTH, 0);
    idle(1);
    runTicks(1, 0);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    runTicks(3, 1);
    idle(3);

    repeat (2) @(posedge clk);
    #2;
    if (expQW.size() != 0 || expQS.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d/%0d expectations left, required 0", expQW.size(),
               expQS.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control FSM and time-of-day counter for the Stopwatch design.
- Sequences the pulse_generator prescaler through its ena/clear inputs from user button pulses.
- Counts its tenth-second ticks into an MM:SS.t BCD time, with lap-freeze of the displayed value.
- Sits between the debounced button edge detectors and the 7-segment display driver.

Parameters:
- WRAP_EN, 1: 1 = wrap 59:59.9 -> 00:00.0 and keep running; 0 = saturate at 59:59.9 and enter PAUSED.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start_stop  input  1  one-cycle pulse; toggles run/pause
- lap  input  1  one-cycle pulse; freezes or unfreezes the displayed time
- clear  input  1  one-cycle pulse; zeroes the time
- tick  input  1  one-cycle pulse from pulse_generator.out, one per 0.1 s
- pg_ena  output  1  drives pulse_generator.ena
- pg_clear  output  1  drives pulse_generator.clear
- running  output  1  high in RUN or LAP
- lapped  output  1  high in LAP (display frozen)
- wrap  output  1  one-cycle pulse when time rolls over or saturates
- disp_min_t  output  3  displayed minutes tens, 0-5
- disp_min_u  output  4  displayed minutes units, 0-9
- disp_sec_t  output  3  displayed seconds tens, 0-5
- disp_sec_u  output  4  displayed seconds units, 0-9
- disp_tenth  output  4  displayed tenths, 0-9

Behaviour:
- Reset (rst=1 at a clk edge) has priority over every other input, in any state:
  - state = IDLE, live and frozen time = 00:00.0, all disp_* = 0
  - pg_ena=0, pg_clear=1, running=0, lapped=0, wrap=0
- All outputs are registered.
- States and outputs:
  - IDLE: pg_ena=0, pg_clear=1
  - RUN: pg_ena=1, pg_clear=0
  - PAUSED: pg_ena=0, pg_clear=0; prescaler phase is preserved
  - LAP: pg_ena=1, pg_clear=0
- Transitions, evaluated once per cycle:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSED; lap -> LAP, and the live time is copied into the frozen register that cycle.
  - LAP: lap -> RUN; start_stop -> PAUSED (display returns to the live time).
  - PAUSED: start_stop -> RUN; clear -> IDLE.
  - clear is ignored in RUN and LAP.
  - lap is ignored in IDLE and PAUSED.
- Simultaneous pulses: priority is clear > start_stop > lap; only the highest applicable pulse acts.
- Counting:
  - A tick is accepted only while the registered state is RUN or LAP.
  - An accepted tick increments the live time by 0.1 s in cascaded BCD: tenth 9->0 carries to sec_u, sec_u 9->0 to sec_t, sec_t 5->0 to min_u, min_u 9->0 to min_t.
  - The increment is visible on disp_* one clk after the tick cycle.
  - A tick arriving in the same cycle as a start_stop that leaves RUN/LAP is still counted.
  - A tick arriving in the same cycle as a start_stop that enters RUN is not counted.
- Limit at 59:59.9 plus an accepted tick:
  - WRAP_EN=1: live time -> 00:00.0, wrap pulses for 1 cycle, state unchanged.
  - WRAP_EN=0: live time holds 59:59.9, wrap pulses for 1 cycle, state -> PAUSED. Later start_stop -> RUN accepts ticks, which saturate again.
- Display selection: disp_* shows the frozen register in LAP, otherwise the live time.
- Entering IDLE via clear: live time zeroed the same cycle; pg_clear=1 from the next cycle.
- Leaving IDLE: pg_clear deasserts in the same cycle pg_ena asserts, so the first tick arrives one full prescaler period after start.
- Reset mid-count: the time is zeroed, and pg_ena drops on the next edge.

Test Plan:
- Reset, then start_stop, then 25 ticks spaced ≥1 clk apart -> disp = 00:02.5, running=1, pg_ena=1, pg_clear=0 from the cycle after start_stop.
- RUN at 00:01.0, lap, then 13 ticks -> disp held at 00:01.0 with lapped=1; second lap -> disp = 00:02.3, lapped=0.
- RUN, start_stop, 5 ticks, start_stop, 3 ticks -> pg_ena low during pause, final disp = 00:00.3 (paused ticks ignored); clear in RUN ignored; start_stop then clear -> disp 00:00.0, pg_clear=1, state IDLE.
- Preload via 35999 ticks to 59:59.9, then 1 tick: WRAP_EN=1 -> 00:00.0, wrap high for exactly 1 cycle, running=1; WRAP_EN=0 -> 59:59.9, wrap 1 cycle, running=0.
- Simultaneous pulses in PAUSED: clear+start_stop -> IDLE. In RUN: start_stop+lap -> PAUSED, lapped=0. tick coincident with start_stop in RUN at 00:00.4 -> 00:00.5 and PAUSED.
- rst asserted in LAP at 12:34.5 -> next edge: all disp_* = 0, pg_ena=0, pg_clear=1, lapped=0, running=0.
